// File: rtl/uop_issue_ctrl.sv
// Dual-thread micro-op issue controller.
// Buffers two per-thread uop streams in small FIFOs, tracks the main thread,
// and slips secondary-thread uops into memory-busy cycles when hazard-free.
// The chosen uop is presented through a registered valid/ready output slot.

module uop_issue_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic [19:0] in_a_uop,
   input  logic        in_a_last,
   input  logic        in_a_valid,
   output logic        in_a_ready,
   input  logic [19:0] in_b_uop,
   input  logic        in_b_last,
   input  logic        in_b_valid,
   output logic        in_b_ready,
   input  logic        ex_doing_mem,
   input  logic        ex_ready,
   output logic [19:0] out_uop,
   output logic        out_valid,
   output logic        out_thread,
   output logic        out_last,
   output logic        main_thread
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   // FIFO entries are {last, uop}; index 0 is thread A, index 1 is thread B.
   logic [20:0]   fifo_mem [2][DEPTH];
   logic [PW-1:0] wr_ptr [2];
   logic [PW-1:0] rd_ptr [2];
   logic [CW-1:0] count [2];

   // Only the fields the hazard check needs are kept from the last issued uop.
   logic          last_store [2];
   logic [3:0]    last_dst [2];
   logic          last_v [2];
   logic          boundary [2];

   logic [20:0]   in_entry [2];
   logic [1:0]    in_valid;
   logic [1:0]    head_v;
   logic [1:0]    ready;
   logic [1:0]    push;
   logic [1:0]    pop;
   logic [20:0]   head [2];

   logic          alt;
   logic [20:0]   alt_head;
   logic [3:0]    alt_src1;
   logic [3:0]    alt_src0;
   logic          main_lv;
   logic          main_store;
   logic [3:0]    main_dst;
   logic          hazard_free;
   logic          alt_eligible;
   logic          idle_switch;
   logic          issue_en;
   logic          issue;
   logic          issue_thread;
   logic [20:0]   issue_entry;
   logic          switch_on_issue;

   assign in_entry[0] = {in_a_last, in_a_uop};
   assign in_entry[1] = {in_b_last, in_b_uop};
   assign in_valid    = {in_b_valid, in_a_valid};

   // Per-thread FIFO status, head entry and accepted pushes.
   always_comb begin
      head_v = '0;
      ready  = '0;
      push   = '0;
      for (int t = 0; t < 2; t++) begin
         head_v[t] = (count[t] != '0);
         ready[t]  = (count[t] != FULL);
         push[t]   = in_valid[t] & ready[t] & ~flush;
         head[t]   = fifo_mem[t][rd_ptr[t]];
      end
   end

   assign in_a_ready = ready[0];
   assign in_b_ready = ready[1];

   assign alt        = ~main_thread;
   assign alt_head   = head[alt];
   assign alt_src1   = {1'b0, alt_head[5:3]};
   assign alt_src0   = {1'b0, alt_head[2:0]};
   assign main_lv    = last_v[main_thread];
   assign main_store = last_store[main_thread];
   assign main_dst   = last_dst[main_thread];

   assign hazard_free  = ~main_lv |
                         (~main_store & (alt_src1 != main_dst) & (alt_src0 != main_dst));
   assign alt_eligible = head_v[alt] & ex_doing_mem & ~alt_head[13] & ~alt_head[20] &
                         hazard_free;
   assign idle_switch  = ~flush & ~head_v[main_thread] & boundary[main_thread] & head_v[alt];
   assign issue_en     = ~out_valid | ex_ready;

   // Issue selection: eligible alternate first, then main head; an idle switch issues nothing.
   always_comb begin
      issue        = 1'b0;
      issue_thread = main_thread;
      if (~flush & issue_en & ~idle_switch) begin
         if (alt_eligible) begin
            issue        = 1'b1;
            issue_thread = alt;
         end else if (head_v[main_thread]) begin
            issue        = 1'b1;
         end
      end
   end

   assign issue_entry     = head[issue_thread];
   assign pop             = {issue & issue_thread, issue & ~issue_thread};
   assign switch_on_issue = issue & (issue_thread == main_thread) & issue_entry[20] &
                            head_v[alt];

   // FIFO pointers and occupancy; flush empties both queues.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < 2; t++) begin
            wr_ptr[t] <= '0;
            rd_ptr[t] <= '0;
            count[t]  <= '0;
         end
      end else if (flush) begin
         for (int t = 0; t < 2; t++) begin
            wr_ptr[t] <= '0;
            rd_ptr[t] <= '0;
            count[t]  <= '0;
         end
      end else begin
         for (int t = 0; t < 2; t++) begin
            if (push[t]) wr_ptr[t] <= wr_ptr[t] + 1'b1;
            if (pop[t])  rd_ptr[t] <= rd_ptr[t] + 1'b1;
            count[t] <= count[t] + CW'(push[t]) - CW'(pop[t]);
         end
      end
   end

   // FIFO storage needs no reset; occupancy decides what is valid.
   always_ff @(posedge clk) begin
      for (int t = 0; t < 2; t++) begin
         if (push[t]) fifo_mem[t][wr_ptr[t]] <= in_entry[t];
      end
   end

   // Per-thread record of the last issued uop and instruction-boundary flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < 2; t++) begin
            last_store[t] <= 1'b0;
            last_dst[t]   <= '0;
            last_v[t]     <= 1'b0;
            boundary[t]   <= 1'b1;
         end
      end else if (flush) begin
         for (int t = 0; t < 2; t++) begin
            last_v[t]   <= 1'b0;
            boundary[t] <= 1'b1;
         end
      end else begin
         for (int t = 0; t < 2; t++) begin
            if (pop[t]) begin
               last_store[t] <= head[t][13];
               last_dst[t]   <= head[t][11:8];
               last_v[t]     <= 1'b1;
               boundary[t]   <= head[t][20];
            end
         end
      end
   end

   // Main thread toggles at an instruction end or on an idle boundary switch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_thread <= 1'b0;
      end else if (idle_switch | switch_on_issue) begin
         main_thread <= ~main_thread;
      end
   end

   // Registered output slot; holds while the execute stage stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_uop    <= '0;
         out_valid  <= 1'b0;
         out_thread <= 1'b0;
         out_last   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (issue) begin
         out_uop    <= issue_entry[19:0];
         out_last   <= issue_entry[20];
         out_thread <= issue_thread;
         out_valid  <= 1'b1;
      end else if (issue_en) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uop_issue_ctrl.sv
// Testbench for uop_issue_ctrl: directed prelude plus randomized traffic,
// checked against a queue-based reference model through a scoreboard.

module tb_uop_issue_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [19:0] in_a_uop = '0;
   logic        in_a_last = 1'b0;
   logic        in_a_valid = 1'b0;
   logic        in_a_ready;
   logic [19:0] in_b_uop = '0;
   logic        in_b_last = 1'b0;
   logic        in_b_valid = 1'b0;
   logic        in_b_ready;
   logic        ex_doing_mem = 1'b0;
   logic        ex_ready = 1'b0;
   logic [19:0] out_uop;
   logic        out_valid;
   logic        out_thread;
   logic        out_last;
   logic        main_thread;

   uop_issue_ctrl #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_a_uop     (in_a_uop),
      .in_a_last    (in_a_last),
      .in_a_valid   (in_a_valid),
      .in_a_ready   (in_a_ready),
      .in_b_uop     (in_b_uop),
      .in_b_last    (in_b_last),
      .in_b_valid   (in_b_valid),
      .in_b_ready   (in_b_ready),
      .ex_doing_mem (ex_doing_mem),
      .ex_ready     (ex_ready),
      .out_uop      (out_uop),
      .out_valid    (out_valid),
      .out_thread   (out_thread),
      .out_last     (out_last),
      .main_thread  (main_thread)
   );

   // Free-running core clock.
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard of expected slot contents {thread, last, uop}, oldest first.
   logic [21:0] sb [$];

   // Reference model: plain queues of {last, uop} per thread plus thread bookkeeping.
   logic [20:0] mqa [$];
   logic [20:0] mqb [$];
   int          m_main;
   bit          m_lv [2];
   bit          m_bnd [2];
   logic [19:0] m_last [2];
   bit          m_slot_v;

   // Expected visible state for the current cycle.
   bit exp_ov = 1'b0;
   bit exp_main = 1'b0;
   bit exp_rdy_a = 1'b1;
   bit exp_rdy_b = 1'b1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int qsize(int t);
      return (t == 0) ? mqa.size() : mqb.size();
   endfunction

   function automatic logic [20:0] qhead(int t);
      return (t == 0) ? mqa[0] : mqb[0];
   endfunction

   function automatic logic [20:0] qpop(int t);
      if (t == 0) return mqa.pop_front();
      return mqb.pop_front();
   endfunction

   function automatic void qpush(int t, logic [20:0] e);
      if (t == 0) mqa.push_back(e);
      else mqb.push_back(e);
   endfunction

   function automatic void modelReset();
      mqa.delete();
      mqb.delete();
      sb.delete();
      m_main = 0;
      for (int t = 0; t < 2; t++) begin
         m_lv[t]   = 1'b0;
         m_bnd[t]  = 1'b1;
         m_last[t] = '0;
      end
      m_slot_v = 1'b0;
   endfunction

   function automatic void snapshot();
      exp_ov    = m_slot_v;
      exp_main  = m_main[0];
      exp_rdy_a = (qsize(0) < DEPTH);
      exp_rdy_b = (qsize(1) < DEPTH);
   endfunction

   // Can the secondary thread slip its head in this cycle?
   function automatic bit altEligible(int a, bit mem);
      logic [20:0] h;
      int s1;
      int s0;
      int d;
      int mn;
      mn = 1 - a;
      if (qsize(a) == 0 || !mem) return 1'b0;
      h = qhead(a);
      if (h[13] || h[20]) return 1'b0;
      if (!m_lv[mn]) return 1'b1;
      if (m_last[mn][13]) return 1'b0;
      s1 = h[5:3];
      s0 = h[2:0];
      d  = m_last[mn][11:8];
      return (s1 != d) && (s0 != d);
   endfunction

   // One clock of stimulus: drive inputs after the edge and advance the model.
   task automatic applyStimulus(input bit va, input logic [19:0] ua, input bit la,
                                input bit vb, input logic [19:0] ub, input bit lb,
                                input bit mem, input bit rdy, input bit fl);
      bit ie;
      bit idle;
      bit ra;
      bit rb;
      int sel;
      int alt;
      logic [20:0] h;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      snapshot();
      in_a_valid = va; in_a_uop = ua; in_a_last = la;
      in_b_valid = vb; in_b_uop = ub; in_b_last = lb;
      ex_doing_mem = mem; ex_ready = rdy; flush = fl;

      alt = 1 - m_main;
      ie  = !m_slot_v || rdy;
      if (fl) begin
         mqa.delete();
         mqb.delete();
         m_slot_v = 1'b0;
         for (int t = 0; t < 2; t++) begin
            m_lv[t]  = 1'b0;
            m_bnd[t] = 1'b1;
         end
      end else begin
         ra   = (qsize(0) < DEPTH);
         rb   = (qsize(1) < DEPTH);
         idle = (qsize(m_main) == 0) && m_bnd[m_main] && (qsize(alt) > 0);
         sel  = -1;
         if (ie && !idle) begin
            if (altEligible(alt, mem)) sel = alt;
            else if (qsize(m_main) > 0) sel = m_main;
         end
         if (sel >= 0) begin
            h = qpop(sel);
            m_last[sel] = h[19:0];
            m_lv[sel]   = 1'b1;
            m_bnd[sel]  = h[20];
            sb.push_back({sel[0], h});
            m_slot_v = 1'b1;
            if (sel == m_main && h[20] && qsize(alt) > 0) m_main = alt;
         end else if (ie) begin
            m_slot_v = 1'b0;
         end
         if (idle) m_main = alt;
         if (va && ra) qpush(0, {la, ua});
         if (vb && rb) qpush(1, {lb, ub});
      end
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      in_a_valid = 1'b0; in_b_valid = 1'b0; flush = 1'b0;
      ex_ready = 1'b0; ex_doing_mem = 1'b0;
      modelReset();
      snapshot();
   endtask

   function automatic logic [19:0] randUop();
      logic [19:0] u;
      u = 20'($urandom);
      u[13] = ($urandom_range(0, 3) == 0);
      u[11:8] = 4'($urandom_range(0, 7));
      return u;
   endfunction

   // Monitor: compares visible state each cycle and retires scoreboard entries.
   initial begin
      forever begin
         @(negedge clk);
         checkOutput("out_valid", 32'(out_valid), 32'(exp_ov));
         checkOutput("main_thread", 32'(main_thread), 32'(exp_main));
         checkOutput("in_a_ready", 32'(in_a_ready), 32'(exp_rdy_a));
         checkOutput("in_b_ready", 32'(in_b_ready), 32'(exp_rdy_b));
         if (!rst_n) begin
            checkOutput("reset_out", 32'({out_thread, out_last, out_uop}), 32'd0);
         end
         if (exp_ov) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("[TB] FAIL scoreboard_empty actual=%h expected=none at %0t",
                        {out_thread, out_last, out_uop}, $time);
            end else begin
               checkOutput("out_slot", 32'({out_thread, out_last, out_uop}), 32'(sb[0]));
               if (ex_ready || flush) void'(sb.pop_front());
            end
         end
      end
   end

   // Driver: directed scenarios first, then randomized traffic with a mid-run reset.
   initial begin
      bit va;
      bit vb;
      int pv;
      modelReset();
      snapshot();
      doReset();

      $display("[TB] directed: single-thread pair");
      applyStimulus(1, 20'h00001, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(1, 20'h00002, 1, 0, 0, 0, 0, 1, 0);
      repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);

      $display("[TB] directed: fill with execute stalled");
      for (int i = 0; i < 5; i++) applyStimulus(1, 20'h00011 + 20'(i), 0, 0, 0, 0, 0, 0, 0);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (8) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);

      $display("[TB] directed: hazard interleave");
      applyStimulus(1, 20'h00300, 0, 0, 0, 0, 1, 1, 0);
      applyStimulus(1, 20'h00500, 0, 1, 20'h00003, 0, 1, 1, 0);
      applyStimulus(1, 20'h00301, 0, 1, 20'h00012, 0, 1, 1, 0);
      repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);

      $display("[TB] directed: switch on last, then flush");
      applyStimulus(1, 20'h00401, 1, 1, 20'h00022, 1, 0, 1, 0);
      repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(1, 20'h00601, 0, 1, 20'h00701, 0, 0, 0, 0);
      applyStimulus(1, 20'h00602, 0, 1, 20'h00702, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 20'h00703, 0, 0, 0, 1);
      repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            doReset();
            continue;
         end
         pv = ((c / 300) % 3 == 0) ? 3 : (((c / 300) % 3 == 1) ? 7 : 10);
         va = ($urandom_range(0, 9) < pv);
         vb = ($urandom_range(0, 9) < pv);
         applyStimulus(va, randUop(), $urandom_range(0, 2) == 0,
                       vb, randUop(), $urandom_range(0, 2) == 0,
                       $urandom_range(0, 1) == 1,
                       $urandom_range(0, 9) < (((c % 700) < 350) ? 8 : 4),
                       $urandom_range(0, 59) == 0);
      end

      repeat (30) applyStimulus(0, 0, 0, 0, 0, 0, $urandom_range(0, 1) == 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      #1;
      checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
